// File: rtl/expr_vector_sequencer_pkg.sv
// Shared definitions for the expression-block vector sequencer: operand packing,
// result width, FSM states and the MISR fold.
package expr_seq_pkg;

  localparam int OPS_W = 60;
  localparam int Y_W   = 90;

  // Operand field LSB positions inside the packed operand bus
  localparam int A0_LSB = 56;
  localparam int A1_LSB = 51;
  localparam int A2_LSB = 45;
  localparam int A3_LSB = 41;
  localparam int A4_LSB = 36;
  localparam int A5_LSB = 30;
  localparam int B0_LSB = 26;
  localparam int B1_LSB = 21;
  localparam int B2_LSB = 15;
  localparam int B3_LSB = 11;
  localparam int B4_LSB = 6;
  localparam int B5_LSB = 0;

  localparam logic [31:0] MISR_POLY_DEF = 32'h04C11DB7;
  localparam logic [31:0] MISR_SEED_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SETTLE_WAIT = 2'd1,
    OUT         = 2'd2
  } seq_state_e;

  // Collapse the 90-bit result into one 32-bit word before it enters the MISR
  function automatic logic [31:0] misr_fold(input logic [Y_W-1:0] y);
    return y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
  endfunction

endpackage

// File: rtl/expr_vector_sequencer_misr.sv
// 32-bit MISR that folds each captured expression result into a running signature.
module expr_misr32
  import expr_seq_pkg::*;
#(
  parameter logic [31:0] POLY = MISR_POLY_DEF,
  parameter logic [31:0] SEED = MISR_SEED_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [Y_W-1:0]   y,
  output logic [31:0]      sig
);

  logic [31:0] sig_q;
  logic [31:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    // clear has priority over a fold in the same cycle
    if (clear) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ misr_fold(y);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/expr_vector_sequencer.sv
// Drives operand vectors into an expression block, samples its result after a
// settle time, checks it against an optional expected value and signs it.
//
// state       | meaning
// IDLE        | ready for a new vector
// SETTLE_WAIT | operands driven, counting down the settle time
// OUT         | captured result presented until the sink takes it
module expr_vector_sequencer
  import expr_seq_pkg::*;
#(
  parameter int unsigned  SETTLE    = 2,
  parameter logic [31:0]  MISR_POLY = MISR_POLY_DEF,
  parameter logic [31:0]  MISR_SEED = MISR_SEED_DEF,
  parameter int unsigned  CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPS_W-1:0]   in_ops,
  input  logic [Y_W-1:0]     in_exp,
  input  logic               in_chk,
  output logic [OPS_W-1:0]   ops_o,
  input  logic [Y_W-1:0]     expr_y_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [Y_W-1:0]     out_y,
  output logic               out_mismatch,
  output logic [31:0]        sig_o,
  output logic [CNT_W-1:0]   vec_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic               busy
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

  seq_state_e         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [OPS_W-1:0]   ops_q, ops_d;
  logic [Y_W-1:0]     exp_q, exp_d;
  logic               chk_q, chk_d;
  logic [Y_W-1:0]     out_y_q, out_y_d;
  logic               mism_q, mism_d;
  logic [CNT_W-1:0]   vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               capture;
  logic               cap_mism;

  assign cap_mism = chk_q & (expr_y_i != exp_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ops_d   = ops_q;
    exp_d   = exp_q;
    chk_d   = chk_q;
    out_y_d = out_y_q;
    mism_d  = mism_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          ops_d   = in_ops;
          exp_d   = in_exp;
          chk_d   = in_chk;
          cnt_d   = SETTLE_INIT;
          state_d = SETTLE_WAIT;
        end
      end
      SETTLE_WAIT: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          out_y_d = expr_y_i;
          mism_d  = cap_mism;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters saturate; clear overrides a capture landing in the same cycle
  always_comb begin
    vec_cnt_d = vec_cnt_q;
    err_cnt_d = err_cnt_q;
    if (clear) begin
      vec_cnt_d = '0;
      err_cnt_d = '0;
    end else if (capture) begin
      if (vec_cnt_q != {CNT_W{1'b1}}) vec_cnt_d = vec_cnt_q + CNT_W'(1);
      if (cap_mism && (err_cnt_q != {CNT_W{1'b1}})) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ops_q     <= '0;
      exp_q     <= '0;
      chk_q     <= 1'b0;
      out_y_q   <= '0;
      mism_q    <= 1'b0;
      vec_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ops_q     <= ops_d;
      exp_q     <= exp_d;
      chk_q     <= chk_d;
      out_y_q   <= out_y_d;
      mism_q    <= mism_d;
      vec_cnt_q <= vec_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  expr_misr32 #(
    .POLY (MISR_POLY),
    .SEED (MISR_SEED)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .en    (capture),
    .y     (expr_y_i),
    .sig   (sig_o)
  );

  assign in_ready     = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign out_valid    = (state_q == OUT);
  assign ops_o        = ops_q;
  assign out_y        = out_y_q;
  assign out_mismatch = mism_q;
  assign vec_cnt      = vec_cnt_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_expr_vector_sequencer.sv
// Scoreboard bench for expr_vector_sequencer: directed vectors push expected
// results, an independent monitor checks them at each output handshake.
module tb_expr_vector_sequencer;

  localparam int ST    = 2;
  localparam int CNT_W = 4;

  typedef struct {
    logic [89:0]      y;
    logic             mism;
    logic [31:0]      sig;
    logic [CNT_W-1:0] vec;
    logic [CNT_W-1:0] err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [59:0]       in_ops;
  logic [89:0]       in_exp;
  logic              in_chk;
  logic [59:0]       ops_o;
  logic [89:0]       expr_y_i;
  logic              out_valid;
  logic              out_ready;
  logic [89:0]       out_y;
  logic              out_mismatch;
  logic [31:0]       sig_o;
  logic [CNT_W-1:0]  vec_cnt;
  logic [CNT_W-1:0]  err_cnt;
  logic              busy;

  logic [89:0]       stub_y;
  exp_t              sb[$];
  int                n_assert = 0;
  int                n_fail = 0;
  logic [31:0]       m_sig;
  logic [CNT_W-1:0]  m_vec;
  logic [CNT_W-1:0]  m_err;
  logic [89:0]       bp_y;

  always #5 clk = ~clk;

  // Stub expression block: result depends on the registered operands
  assign expr_y_i = stub_y ^ {30'b0, ops_o};

  expr_vector_sequencer #(.SETTLE(ST), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_ops(in_ops),
    .in_exp(in_exp), .in_chk(in_chk), .ops_o(ops_o), .expr_y_i(expr_y_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_mismatch(out_mismatch), .sig_o(sig_o), .vec_cnt(vec_cnt),
    .err_cnt(err_cnt), .busy(busy)
  );

  task automatic check(input string name, input logic [89:0] act, input logic [89:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ref_misr(input logic [31:0] s, input logic [89:0] y);
    logic [31:0] f;
    f = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
  endfunction

  task automatic model_clear();
    m_sig = 32'h0;
    m_vec = '0;
    m_err = '0;
  endtask

  // Monitor: one comparison set per output handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 90'd1, 90'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_out_y", out_y, e.y);
        check("sb_out_mismatch", 90'(out_mismatch), 90'(e.mism));
        check("sb_sig_o", 90'(sig_o), 90'(e.sig));
        check("sb_vec_cnt", 90'(vec_cnt), 90'(e.vec));
        check("sb_err_cnt", 90'(err_cnt), 90'(e.err));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", 90'(in_ready), 90'd1);
  endtask

  task automatic send(input logic [59:0] ops, input logic [89:0] ex, input logic ck,
                      input logic [89:0] sy, input bit clr_cap);
    exp_t e;
    logic [89:0] y;
    wait_ready();
    y = sy ^ {30'b0, ops};
    e.y = y;
    e.mism = ck && (y != ex);
    if (clr_cap) begin
      model_clear();
    end else begin
      m_sig = ref_misr(m_sig, y);
      if (m_vec != {CNT_W{1'b1}}) m_vec = m_vec + 1'b1;
      if (e.mism && m_err != {CNT_W{1'b1}}) m_err = m_err + 1'b1;
    end
    e.sig = m_sig;
    e.vec = m_vec;
    e.err = m_err;
    sb.push_back(e);
    stub_y = sy; in_ops = ops; in_exp = ex; in_chk = ck; in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs: the sequencer must hold what it latched
    in_valid = 1'b0; in_ops = ~ops; in_exp = ~ex; in_chk = ~ck;
    check("ops_o_after_accept", 90'(ops_o), 90'(ops));
    check("busy_settle", 90'(busy), 90'd1);
    repeat (ST - 1) @(posedge clk);
    #1;
    check("no_valid_before_capture", 90'(out_valid), 90'd0);
    if (clr_cap) clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("valid_at_capture", 90'(out_valid), 90'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("scoreboard_drained", 90'(sb.size()), 90'd0);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_ops = '0; in_exp = '0;
    in_chk = 1'b0; out_ready = 1'b1; stub_y = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 90'(in_ready), 90'd1);
    check("rst_busy", 90'(busy), 90'd0);
    check("rst_out_valid", 90'(out_valid), 90'd0);
    check("rst_ops_o", 90'(ops_o), 90'd0);
    check("rst_out_y", out_y, 90'd0);
    check("rst_sig_o", 90'(sig_o), 90'd0);
    check("rst_vec_cnt", 90'(vec_cnt), 90'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic latency, y = 0
    send(60'h0, 90'h0, 1'b0, 90'h0, 1'b0);
    check("basic_sig", 90'(sig_o), 90'h0);
    check("basic_vec_cnt", 90'(vec_cnt), 90'd1);
    drain();

    // MISR: two vectors with y = 1
    send(60'h0, 90'h0, 1'b0, 90'h1, 1'b0);
    check("misr_first", 90'(sig_o), 90'h1);
    drain();
    send(60'h0, 90'h0, 1'b0, 90'h1, 1'b0);
    check("misr_second", 90'(sig_o), 90'h3);
    drain();

    // Compare path
    send(60'h0, 90'h5, 1'b1, 90'h4, 1'b0);
    check("cmp_mismatch", 90'(out_mismatch), 90'd1);
    check("cmp_err_cnt", 90'(err_cnt), 90'd1);
    drain();
    send(60'h0, 90'h4, 1'b1, 90'h4, 1'b0);
    check("cmp_match", 90'(out_mismatch), 90'd0);
    check("cmp_err_hold", 90'(err_cnt), 90'd1);
    drain();

    // Wide vector touching all fold segments, expected value matches
    send(60'hABCDEF012345678, 90'h2AA5555AAAA0F0FF0F01234 ^ 90'hABCDEF012345678, 1'b1,
         90'h2AA5555AAAA0F0FF0F01234, 1'b0);
    drain();

    // Backpressure
    out_ready = 1'b0;
    bp_y = 90'h1_0000_0000_0000_0000_0042;
    send(60'h0, 90'h0, 1'b0, bp_y, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid", 90'(out_valid), 90'd1);
      check("bp_out_y", out_y, bp_y);
      check("bp_in_ready", 90'(in_ready), 90'd0);
      check("bp_vec_cnt", 90'(vec_cnt), 90'(m_vec));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 90'(in_ready), 90'd1);
    check("bp_release_valid", 90'(out_valid), 90'd0);
    drain();

    // Clear colliding with capture
    send(60'h0, 90'h0, 1'b1, 90'h77, 1'b1);
    check("clr_cap_sig", 90'(sig_o), 90'h0);
    check("clr_cap_vec", 90'(vec_cnt), 90'd0);
    check("clr_cap_err", 90'(err_cnt), 90'd0);
    check("clr_cap_out_y", out_y, 90'h77);
    drain();

    // Standalone clear in IDLE
    send(60'h5, 90'h0, 1'b1, 90'h30, 1'b0);
    drain();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
    check("clr_idle_sig", 90'(sig_o), 90'h0);
    check("clr_idle_vec", 90'(vec_cnt), 90'd0);
    check("clr_idle_err", 90'(err_cnt), 90'd0);

    // Reset mid-flight
    wait_ready();
    stub_y = 90'h9; in_ops = 60'h123; in_chk = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    model_clear();
    check("abort_out_valid", 90'(out_valid), 90'd0);
    check("abort_ops_o", 90'(ops_o), 90'd0);
    check("abort_busy", 90'(busy), 90'd0);
    check("abort_in_ready", 90'(in_ready), 90'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_no_valid", 90'(out_valid), 90'd0);
    end
    send(60'h3C, 90'h0, 1'b0, 90'h100, 1'b0);
    drain();

    // Counter saturation, every vector a mismatch
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
    for (int i = 0; i < 17; i++) begin
      send(60'(i), 90'h0, 1'b1, 90'h800 + 90'(i), 1'b0);
      drain();
    end
    check("sat_vec_cnt", 90'(vec_cnt), 90'hF);
    check("sat_err_cnt", 90'(err_cnt), 90'hF);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/expr_vector_sequencer.md
Name: expr_vector_sequencer

Overview:
- Drives operand vectors into one combinational expression block under test (operand ports a0..a5/b0..b5, 90-bit result y).
- Waits a programmable settle time, captures y and compares it against an optional expected value.
- Folds every captured result into a 32-bit MISR signature.
- Sits between the regression stimulus source (valid/ready) and a result sink, so one sequencer exercises any expression block in the regression suite.

Parameters:
- SETTLE, 2, cycles between driving operands and sampling expr_y_i; legal range 1..15.
- MISR_POLY, 32'h04C11DB7, MISR feedback polynomial.
- MISR_SEED, 32'h00000000, signature value after reset or clear.
- CNT_W, 16, width of the vector and error counters.

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous; sig_o := MISR_SEED, vec_cnt := 0, err_cnt := 0
- in_valid  in  1  stimulus vector valid
- in_ready  out  1  sequencer can accept a vector
- in_ops  in  60  packed operands: [59:56]a0 [55:51]a1 [50:45]a2 [44:41]a3 [40:36]a4 [35:30]a5 [29:26]b0 [25:21]b1 [20:15]b2 [14:11]b3 [10:6]b4 [5:0]b5
- in_exp  in  90  expected y
- in_chk  in  1  compare against in_exp for this vector
- ops_o  out  60  registered operands to the expression block, same packing as in_ops
- expr_y_i  in  90  combinational result from the expression block
- out_valid  out  1  result available
- out_ready  in  1  sink accepts the result
- out_y  out  90  captured y
- out_mismatch  out  1  in_chk was set and captured y != in_exp
- sig_o  out  32  current MISR signature
- vec_cnt  out  CNT_W  vectors completed; saturating
- err_cnt  out  CNT_W  mismatches; saturating
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, rst_n=0):
  - FSM = IDLE; ops_o = 0; out_y = 0; out_valid = 0; out_mismatch = 0.
  - sig_o = MISR_SEED; vec_cnt = 0; err_cnt = 0; in_ready = 1; busy = 0.
- States: IDLE, SETTLE_WAIT, OUT.
- IDLE:
  - in_ready = 1.
  - On edge with in_valid=1: ops_o := in_ops; in_exp and in_chk are latched; settle counter := SETTLE-1; go to SETTLE_WAIT.
- SETTLE_WAIT:
  - in_ready = 0; ops_o held stable.
  - Counter decrements each cycle.
  - On the edge where the counter equals 0: out_y := expr_y_i; out_mismatch := chk & (expr_y_i != exp); MISR update; vec_cnt += 1; err_cnt += mismatch; go to OUT.
  - Capture happens exactly SETTLE edges after the accept edge.
- OUT:
  - out_valid = 1; out_y and out_mismatch held stable.
  - On edge with out_ready=1: out_valid := 0; go to IDLE.
  - No new vector is accepted in OUT. Minimum period is SETTLE+2 cycles per vector.
- MISR update:
  - f = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]}.
  - sig := {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 0) ^ f.
- Counters saturate at all-ones and never wrap.
- Comparison is bitwise over all 90 bits, unsigned. Signedness of individual fields is irrelevant to the sequencer.
- clear:
  - Affects only sig_o and the counters; the FSM and the in-flight vector continue unaffected.
  - clear in the same cycle as a capture: clear wins. sig_o = MISR_SEED and counters = 0, but out_y and out_mismatch are still produced for that vector.
- Asserting rst_n low mid-operation aborts the vector; no out_valid is issued for it.
- out_ready asserted while out_valid is low is ignored.

Decomposition:
- Package expr_seq_pkg holds:
  - operand field offsets/widths (A0_LSB..B5_LSB, OPS_W=60), Y_W=90
  - MISR fold function
  - state enum {IDLE, SETTLE_WAIT, OUT}
  - default MISR_POLY / MISR_SEED
- One sub-module expr_misr32: inputs clk, rst_n, clear, en, y[89:0]; output sig[31:0].

Test Plan:
- Basic latency: SETTLE=2, stub y=0, in_ops=0, in_chk=0 -> ops_o=0 one edge after accept; capture 2 edges after accept; out_valid=1; out_y=0; sig_o=0x00000000; vec_cnt=1.
- MISR: seed 0, two vectors with stub returning y=90'h1 -> sig_o=0x00000001 after the first vector, 0x00000003 after the second.
- Compare: in_chk=1, in_exp=90'h5, stub y=90'h4 -> out_mismatch=1, err_cnt=1. Repeat with in_exp=90'h4 -> out_mismatch=0, err_cnt stays 1.
- Backpressure: out_ready=0 for 10 cycles -> out_valid and out_y stable, in_ready=0, vec_cnt unchanged. out_ready=1 -> IDLE next cycle, in_ready=1.
- Clear collision: clear=1 on the capture edge -> sig_o=MISR_SEED, vec_cnt=0, err_cnt=0, out_valid still 1 with the correct out_y.
- Reset mid-flight: rst_n=0 during SETTLE_WAIT -> out_valid=0, ops_o=0, busy=0 immediately. After release, the next vector is accepted normally.
